ex_operand_stage: RTL and testbench

- Pipeline register and operand-resolution stage directly upstream of the ALU.
- Accepts decoded instructions from ID and resolves rs1/rs2 through forwarding from EX/MEM and MEM/WB.
- Selects register or immediate for SrcB and presents registered SrcA/SrcB/Operation to the ALU.
- Uses a valid/ready handshake with a one-entry skid buffer, load-use stall detection and flush.

---
 rtl/ex_pkg.sv | 37 +++
 rtl/ex_operand_stage_fwd_mux.sv | 30 +++
 rtl/ex_operand_stage.sv | 141 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the EX operand stage: ALU opcodes,
// the registered payload presented to the ALU, and occupancy states.
package ex_pkg;

  localparam int EX_DATA_W = 32;
  localparam int EX_OP_W   = 4;
  localparam int EX_REG_W  = 5;

  localparam logic [EX_OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [EX_OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [EX_OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [EX_OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [EX_OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [EX_OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [EX_OP_W-1:0] OP_SRL = 4'b0110;
  localparam logic [EX_OP_W-1:0] OP_SRA = 4'b0111;
  localparam logic [EX_OP_W-1:0] OP_EQ  = 4'b1000;
  localparam logic [EX_OP_W-1:0] OP_NE  = 4'b1001;
  localparam logic [EX_OP_W-1:0] OP_LT  = 4'b1010;
  localparam logic [EX_OP_W-1:0] OP_GE  = 4'b1011;

  typedef struct packed {
    logic [EX_DATA_W-1:0] SrcA;
    logic [EX_DATA_W-1:0] SrcB;
    logic [EX_DATA_W-1:0] StoreData;
    logic [EX_OP_W-1:0]   Operation;
    logic [EX_REG_W-1:0]  rd;
  } ex_payload_t;

  // EMPTY: nothing held; ONE: output register only; TWO: output + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Resolves one source operand: x0, then EX/MEM bypass (non-load only),
// then MEM/WB bypass, then register-file data.
module fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0]     rf_data_i,
  input  logic                      exm_regwrite_i,
  input  logic                      exm_memread_i,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
  input  logic [DATA_WIDTH-1:0]     exm_result_i,
  input  logic                      wb_regwrite_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic [DATA_WIDTH-1:0]     value_o
);

  always_comb begin
    value_o = rf_data_i;
    if (idx_i == '0) begin
      value_o = '0;
    end else if (exm_regwrite_i && !exm_memread_i && (exm_rd_i == idx_i)) begin
      value_o = exm_result_i;
    end else if (wb_regwrite_i && (wb_rd_i == idx_i)) begin
      value_o = wb_data_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Operand-resolution pipeline register in front of the ALU, with a
// one-entry skid buffer, load-use stall and flush.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH     = EX_DATA_W,
  parameter int OPCODE_LENGTH  = EX_OP_W,
  parameter int REG_ADDR_WIDTH = EX_REG_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  in_operation,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      exm_regwrite,
  input  logic                      exm_memread,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic                      wb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [DATA_WIDTH-1:0]     StoreData,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output stage_state_t              dbg_state_o
);

  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;
  logic                  hazard;
  logic                  accept;
  logic                  consume;
  ex_payload_t           in_pl;
  ex_payload_t           out_q, out_d;
  ex_payload_t           skid_q, skid_d;
  stage_state_t          state_q, state_d;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .idx_i(in_rs1), .rf_data_i(in_rs1_data),
    .exm_regwrite_i(exm_regwrite), .exm_memread_i(exm_memread),
    .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .value_o(fwd_rs1)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .idx_i(in_rs2), .rf_data_i(in_rs2_data),
    .exm_regwrite_i(exm_regwrite), .exm_memread_i(exm_memread),
    .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .value_o(fwd_rs2)
  );

  // Any rs2 match stalls, whether rs2 feeds SrcB or only StoreData.
  assign hazard = in_valid && exm_memread && exm_regwrite && (exm_rd != '0) &&
                  ((exm_rd == in_rs1) || (exm_rd == in_rs2));

  always_comb begin
    in_pl           = '0;
    in_pl.SrcA      = fwd_rs1;
    in_pl.SrcB      = in_alu_src ? in_imm : fwd_rs2;
    in_pl.StoreData = fwd_rs2;
    in_pl.Operation = in_operation;
    in_pl.rd        = in_rd;
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on registered occupancy, hazard and reset, never on out_ready.
  assign in_ready  = (state_q != ST_TWO) && !hazard && !reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = in_pl;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b11: out_d = in_pl;
            2'b01: state_d = ST_EMPTY;
            2'b10: begin
              state_d = ST_TWO;
              skid_d  = in_pl;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (consume) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign SrcA        = out_q.SrcA;
  assign SrcB        = out_q.SrcB;
  assign StoreData   = out_q.StoreData;
  assign Operation   = out_q.Operation;
  assign out_rd      = out_q.rd;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios then random traffic,
// checked against a two-deep queue model of the stage.
module tb_ex_operand_stage;
  import ex_pkg::*;

  localparam int PW = 3 * 32 + 4 + 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic        in_alu_src = 1'b0;
  logic [3:0]  in_operation = '0;
  logic        exm_regwrite = 1'b0, exm_memread = 1'b0;
  logic [4:0]  exm_rd = '0;
  logic [31:0] exm_result = '0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] SrcA, SrcB, StoreData;
  logic [3:0]  Operation;
  logic [4:0]  out_rd;
  stage_state_t dbg_state;

  logic [PW-1:0] exp_q[$];
  bit            zero_exp = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src),
    .in_operation(in_operation), .in_rd(in_rd),
    .exm_regwrite(exm_regwrite), .exm_memread(exm_memread),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .StoreData(StoreData),
    .Operation(Operation), .out_rd(out_rd),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0) return 32'd0;
    if (exm_regwrite && !exm_memread && exm_rd == s) return exm_result;
    if (wb_regwrite && wb_rd == s) return wb_data;
    return rf;
  endfunction

  // One clock: check in_ready before the edge, update the model, check outputs after.
  task automatic tick();
    bit            haz, exp_rdy, acc, cons;
    logic [31:0]   a, b, sd;
    logic [PW-1:0] head;
    @(negedge clk);
    haz = in_valid && exm_memread && exm_regwrite && exm_rd != 5'd0 &&
          (exm_rd == in_rs1 || exm_rd == in_rs2);
    exp_rdy = !reset && exp_q.size() < 2 && !haz;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    acc  = in_valid && exp_rdy && !flush;
    cons = out_ready && exp_q.size() > 0;
    a  = fwd(in_rs1, in_rs1_data);
    sd = fwd(in_rs2, in_rs2_data);
    b  = in_alu_src ? in_imm : sd;
    @(posedge clk);
    #1;
    if (reset || flush) begin
      exp_q.delete();
      if (reset) zero_exp = 1'b1;
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({a, b, sd, in_operation, in_rd});
    end
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    check("occupancy", {62'd0, dbg_state}, 64'(exp_q.size()));
    if (exp_q.size() > 0) begin
      zero_exp = 1'b0;
      head = exp_q[0];
      check("SrcA", {32'd0, SrcA}, {32'd0, head[PW-1 -: 32]});
      check("SrcB", {32'd0, SrcB}, {32'd0, head[PW-33 -: 32]});
      check("StoreData", {32'd0, StoreData}, {32'd0, head[PW-65 -: 32]});
      check("Operation", {60'd0, Operation}, {60'd0, head[8:5]});
      check("out_rd", {59'd0, out_rd}, {59'd0, head[4:0]});
    end else if (zero_exp) begin
      check("reset_zero", {SrcA, SrcB} | {StoreData, 23'd0, Operation, out_rd}, 64'd0);
    end
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic alu_src,
                           input logic [3:0] op, input logic [4:0] rd);
    in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_imm = imm; in_alu_src = alu_src; in_operation = op; in_rd = rd;
  endtask

  task automatic set_byp(input logic erw, input logic emr, input logic [4:0] erd,
                         input logic [31:0] eres, input logic wrw,
                         input logic [4:0] wrd, input logic [31:0] wd);
    exm_regwrite = erw; exm_memread = emr; exm_rd = erd; exm_result = eres;
    wb_regwrite = wrw; wb_rd = wrd; wb_data = wd;
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Plain ADD, no bypass.
    set_byp(0, 0, 0, 0, 0, 0, 0);
    set_instr(3, 10, 4, 20, 0, 0, OP_ADD, 5'd5);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    check("tp_add_srca", {32'd0, SrcA}, 64'd10);
    check("tp_add_srcb", {32'd0, SrcB}, 64'd20);
    check("tp_add_op", {60'd0, Operation}, 64'(OP_ADD));
    tick();

    // EX/MEM beats MEM/WB; x0 beats both.
    set_byp(1, 0, 3, 99, 1, 3, 55);
    in_valid = 1;
    tick();
    check("tp_exm_wins", {32'd0, SrcA}, 64'd99);
    in_rs1 = 0;
    tick();
    check("tp_x0", {32'd0, SrcA}, 64'd0);
    in_valid = 0;
    set_byp(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Load-use stall on rs2, then MEM/WB forward.
    set_byp(1, 1, 4, 32'hDEAD, 0, 0, 0);
    set_instr(1, 1, 4, 20, 0, 0, OP_SUB, 5'd6);
    in_valid = 1;
    tick();
    check("tp_stall", {63'd0, in_ready}, 64'd0);
    set_byp(0, 0, 0, 0, 1, 4, 7);
    tick();
    check("tp_wb_srcb", {32'd0, SrcB}, 64'd7);
    in_valid = 0;
    set_byp(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Backpressure fills the skid, then drains in order.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'(i + 1), 32'(100 + i), 5'(i + 2), 32'(200 + i), 0, 0, OP_XOR, 5'(10 + i));
      tick();
    end
    check("tp_hold_rd", {59'd0, out_rd}, 64'd10);
    out_ready = 1; in_valid = 0;
    tick();
    check("tp_drain_rd", {59'd0, out_rd}, 64'd11);
    tick(); tick();

    // Flush while full drops everything, including the offered instruction.
    out_ready = 0; in_valid = 1;
    tick(); tick();
    flush = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    tick();

    // Immediate operand; StoreData still carries rs2.
    set_instr(2, 1, 6, 5, 32'hFFFF_FFF0, 1, OP_ADD, 5'd7);
    in_valid = 1;
    tick();
    check("tp_imm_srcb", {32'd0, SrcB}, 64'hFFFF_FFF0);
    check("tp_imm_store", {32'd0, StoreData}, 64'd5);

    // Reset mid-stream with a held entry.
    out_ready = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; out_ready = 1; in_valid = 0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      set_instr(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
                5'($urandom_range(0, 31)));
      set_byp(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
